iterative_left_shift: RTL and testbench
=======================================

Name: iterative_left_shift

Overview:
- Multi-cycle logical left shifter for the ALU datapath. It is the opposite direction of the single-step right shift used there.
- Shifts a latched operand left by one bit per clock until the requested shift amount is reached, then pulses done.
- Flags any non-zero bits lost off the top and any change of the sign bit, so the ALU can report shift overflow.
- Sits beside the combinational shift units as a low-area alternative for the sll path.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SHAMT_W, 5, shift-amount width; must satisfy 2**SHAMT_W == WIDTH.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only when busy=0.
- data_in  input  WIDTH  operand, captured on an accepted start.
- shamt  input  SHAMT_W  shift amount, captured on an accepted start.
- busy  output  1  high from the accepted start until done has been asserted.
- done  output  1  one-cycle pulse: result and flags are valid.
- result  output  WIDTH  shifted operand; held stable after done until the next accepted start.
- bits_lost  output  1  1 if any 1-bit was shifted out of bit WIDTH-1.
- sign_changed  output  1  1 if bit WIDTH-1 differed from data_in[WIDTH-1] after any single step (signed overflow).

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE, busy=0, done=0, result=0, bits_lost=0, sign_changed=0, internal count=0.
  - Takes effect immediately, even mid-operation. The aborted operation never produces done.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1: latch data_in into result, shamt into count, sign0=data_in[WIDTH-1].
  - Clear bits_lost and sign_changed; set busy=1.
  - Next state is DONE if shamt==0, otherwise SHIFT.
- SHIFT (each edge):
  - bits_lost |= result[WIDTH-1].
  - result <= {result[WIDTH-2:0], 1'b0}.
  - sign_changed |= (result[WIDTH-2] != sign0).
  - count <= count-1.
  - When count==1 on this edge, next state is DONE.
- DONE:
  - done=1 and busy=1 for exactly one cycle; next edge returns to IDLE with busy=0, done=0.
  - result and flags hold their values in IDLE.
- Latency: for shamt=N, done is high in the (N+1)-th cycle after the cycle in which start was sampled.
  - Minimum is 1 cycle (N=0); maximum is WIDTH cycles (N=WIDTH-1).
- start while busy=1 (SHIFT or DONE) is ignored; the in-flight operation is unaffected. There is no queueing.
- A start arriving on the same edge that DONE returns to IDLE is not accepted, because busy=1 on that edge.
  - The earliest new acceptance is the edge after done deasserts.
- data_in and shamt are don't-care except on the accepting edge.
- Outputs are registered; no combinational path from inputs to outputs.
- Fill bits are always 0 (logical shift); no wrap-around of shifted-out bits.

Test Plan:
- Reset then idle: resetn=0 -> all outputs 0. Release with start=0 for 10 cycles -> busy=0, done never asserts.
- Zero shift: data_in=32'hDEADBEEF, shamt=0 -> done in the 1st cycle after start; result=32'hDEADBEEF, bits_lost=0, sign_changed=0.
- Normal shift: data_in=32'h0000_0001, shamt=4 -> busy high for 5 cycles, done in cycle 5; result=32'h0000_0010, both flags 0.
- Overflow and max shift:
  - data_in=32'h4000_0003, shamt=31 -> done in cycle 32; result=32'h8000_0000; bits_lost=1, sign_changed=1.
  - data_in=32'hC000_0000, shamt=1 -> result=32'h8000_0000, bits_lost=1, sign_changed=0.
- Busy rejection and back-to-back:
  - Start shamt=3 on data_in=32'h1, then pulse start with data_in=32'hFFFF_FFFF during SHIFT -> result=32'h8, no second done.
  - A start issued the cycle after done deasserts is accepted normally.
- Reset mid-operation: start shamt=20, assert resetn=0 at cycle 7 -> outputs clear immediately, no done. After release, a fresh start with shamt=2, data_in=32'h3 -> result=32'hC.

Source files
------------

// File: rtl/iterative_left_shift_if.sv
// rtl/iterative_left_shift_if.sv - request/result bundle for the iterative left shifter
//
// Purpose: groups the start/operand request and the registered result/flags
// of iterative_left_shift into one interface.
// Signals:
//   start        request pulse (master -> slave)
//   data_in      operand, WIDTH bits (master -> slave)
//   shamt        shift amount, SHAMT_W bits (master -> slave)
//   busy         operation in flight (slave -> master)
//   done         one-cycle completion pulse (slave -> master)
//   result       shifted operand (slave -> master)
//   bits_lost    a 1-bit was shifted out of the top (slave -> master)
//   sign_changed top bit differed from the original sign after some step
interface iterative_left_shift_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  logic               bits_lost;
  logic               sign_changed;

  modport master (
    output start, data_in, shamt,
    input  busy, done, result, bits_lost, sign_changed
  );

  modport slave (
    input  start, data_in, shamt,
    output busy, done, result, bits_lost, sign_changed
  );
endinterface

// File: rtl/iterative_left_shift.sv
// rtl/iterative_left_shift.sv - multi-cycle logical left shifter with overflow flags
//
// Purpose: latches an operand and shift amount on an accepted start, shifts
// left one bit per clock, then pulses done. Tracks 1-bits lost off the top
// and any change of the sign bit across the individual steps.
// Ports:
//   clock   rising-edge system clock
//   resetn  asynchronous active-low reset
//   bus     iterative_left_shift_if.slave (start/data_in/shamt in;
//           busy/done/result/bits_lost/sign_changed out, all registered)
module iterative_left_shift #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic                   clock,
  input  logic                   resetn,
  iterative_left_shift_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_result;
  logic [SHAMT_W-1:0] r_count;
  logic               r_sign0;
  logic               r_bits_lost;
  logic               r_sign_changed;
  logic               r_busy;
  logic               r_done;

  // Starts are only seen in IDLE, which is exactly when busy is low.
  logic               w_accept;
  logic               w_last_step;

  assign w_accept    = (r_state == IDLE) && bus.start;
  assign w_last_step = (r_count == SHAMT_W'(1));

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = (bus.shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (w_last_step) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered status outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_result       <= '0;
      r_count        <= '0;
      r_sign0        <= 1'b0;
      r_bits_lost    <= 1'b0;
      r_sign_changed <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      // busy/done are decoded from the next state so they line up with the
      // state register without a combinational path to the outputs.
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (w_state_nxt == DONE);

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_result       <= bus.data_in;
            r_count        <= bus.shamt;
            r_sign0        <= bus.data_in[WIDTH-1];
            r_bits_lost    <= 1'b0;
            r_sign_changed <= 1'b0;
          end
        end
        SHIFT: begin
          r_bits_lost <= r_bits_lost | r_result[WIDTH-1];
          r_result    <= {r_result[WIDTH-2:0], 1'b0};
          // result[WIDTH-2] becomes the new top bit after this step.
          r_sign_changed <= r_sign_changed | (r_result[WIDTH-2] != r_sign0);
          r_count     <= r_count - SHAMT_W'(1);
        end
        default: begin
          // DONE: hold result and flags for the consumer.
        end
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.result       = r_result;
  assign bus.bits_lost    = r_bits_lost;
  assign bus.sign_changed = r_sign_changed;

endmodule

// File: tb/tb_iterative_left_shift.sv
// tb/tb_iterative_left_shift.sv - self-checking bench for iterative_left_shift
module tb_iterative_left_shift;

  localparam int W  = 32;
  localparam int SW = 5;

  logic clock;
  logic resetn;
  int   n_cmp;
  int   n_err;

  iterative_left_shift_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();

  iterative_left_shift #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: the whole shift done at once with wide arithmetic.
  // Sign changes at some step iff the top s+1 bits of the operand are not all equal.
  task automatic model(input logic [W-1:0] d, input logic [SW-1:0] s,
                       output logic [W-1:0] r, output logic bl, output logic sc);
    logic [63:0] wide;
    logic [63:0] top;
    logic [63:0] mask;
    wide = {32'd0, d} << s;
    r    = wide[31:0];
    bl   = (wide[63:32] != 64'd0);
    top  = {32'd0, d} >> (31 - int'(s));
    mask = (64'd1 << (int'(s) + 1)) - 64'd1;
    sc   = !((top == 64'd0) || (top == mask));
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, ".busy"}, 64'(bus.busy), 64'd0);
    check({tag, ".done"}, 64'(bus.done), 64'd0);
    check({tag, ".result"}, 64'(bus.result), 64'd0);
    check({tag, ".bits_lost"}, 64'(bus.bits_lost), 64'd0);
    check({tag, ".sign_changed"}, 64'(bus.sign_changed), 64'd0);
  endtask

  // Issue one operation and verify latency, busy, result and flags.
  // intrude: pulse a conflicting start two cycles in (ignored while busy).
  task automatic do_op(input string tag, input logic [W-1:0] d, input logic [SW-1:0] s,
                       input bit intrude);
    logic [W-1:0] er;
    logic         ebl;
    logic         esc;
    int           cycles;
    model(d, s, er, ebl, esc);
    @(negedge clock);
    bus.start   = 1'b1;
    bus.data_in = d;
    bus.shamt   = s;
    @(negedge clock);
    bus.start   = 1'b0;
    bus.data_in = $urandom;
    bus.shamt   = SW'($urandom);
    cycles = 1;
    while (!bus.done && cycles < 64) begin
      check({tag, ".busy_mid"}, 64'(bus.busy), 64'd1);
      if (intrude && cycles == 2) begin
        bus.start   = 1'b1;
        bus.data_in = '1;
        bus.shamt   = SW'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clock);
      cycles++;
    end
    bus.start = 1'b0;
    check({tag, ".latency"}, 64'(cycles), 64'(int'(s) + 1));
    check({tag, ".busy_at_done"}, 64'(bus.busy), 64'd1);
    check({tag, ".result"}, 64'(bus.result), 64'(er));
    check({tag, ".bits_lost"}, 64'(bus.bits_lost), 64'(ebl));
    check({tag, ".sign_changed"}, 64'(bus.sign_changed), 64'(esc));
    @(negedge clock);
    check({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
    check({tag, ".busy_after"}, 64'(bus.busy), 64'd0);
    check({tag, ".result_held"}, 64'(bus.result), 64'(er));
  endtask

  initial begin
    logic [W-1:0] rd;
    logic [SW-1:0] rs;
    n_cmp = 0;
    n_err = 0;
    bus.start   = 1'b0;
    bus.data_in = '0;
    bus.shamt   = '0;
    resetn      = 1'b0;

    // Reset then idle
    #3;
    check_idle_zero("reset");
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("idle.busy", 64'(bus.busy), 64'd0);
      check("idle.done", 64'(bus.done), 64'd0);
    end

    // Directed cases
    do_op("zero", 32'hDEADBEEF, 5'd0, 1'b0);
    do_op("normal", 32'h0000_0001, 5'd4, 1'b0);
    do_op("max", 32'h4000_0003, 5'd31, 1'b0);
    do_op("top_lost", 32'hC000_0000, 5'd1, 1'b0);
    do_op("busy_rej", 32'h0000_0001, 5'd3, 1'b1);
    repeat (2) begin
      @(negedge clock);
      check("busy_rej.no_second_done", 64'(bus.done), 64'd0);
      check("busy_rej.result", 64'(bus.result), 64'h8);
    end

    // Start on the DONE->IDLE edge is refused; held one more edge it is accepted.
    @(negedge clock);
    bus.start = 1'b1; bus.data_in = 32'h0000_0005; bus.shamt = 5'd1;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    check("b2b.first_done", 64'(bus.done), 64'd1);
    bus.start = 1'b1; bus.data_in = 32'h1234_5678; bus.shamt = 5'd0;
    @(negedge clock);
    check("b2b.refused_busy", 64'(bus.busy), 64'd0);
    check("b2b.refused_done", 64'(bus.done), 64'd0);
    check("b2b.refused_result", 64'(bus.result), 64'hA);
    @(negedge clock);
    bus.start = 1'b0;
    check("b2b.accepted_done", 64'(bus.done), 64'd1);
    check("b2b.accepted_result", 64'(bus.result), 64'h1234_5678);
    @(negedge clock);

    // Reset mid-operation
    @(negedge clock);
    bus.start = 1'b1; bus.data_in = 32'h0000_0001; bus.shamt = 5'd20;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (6) @(negedge clock);
    resetn = 1'b0;
    #1;
    check_idle_zero("midrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("midrst.hold_done", 64'(bus.done), 64'd0);
    end
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("midrst.no_done", 64'(bus.done), 64'd0);
    end
    do_op("after_rst", 32'h0000_0003, 5'd2, 1'b0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      rd = $urandom;
      case ($urandom_range(0, 3))
        0: rd = rd >> $urandom_range(0, 31);
        1: rd = ~(rd >> $urandom_range(0, 31));
        default: ;
      endcase
      rs = SW'($urandom);
      do_op("rand", rd, rs, ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
